// File: rtl/mem_copy_engine_if.sv
// ---------------------------------------------------------------------------
// mem_copy_engine_if
// Bundles the start/busy/done handshake and the single-port memory bus used
// by mem_copy_engine.
//   slave  modport : the copy engine (takes requests, drives the memory bus)
//   master modport : the environment (controller issuing requests plus the
//                    memory returning combinational read data)
// Signals:
//   start, src_addr, dst_addr, length    request from controller
//   busy, done, err, checksum            status back to controller
//   mem_write_enable, mem_address,
//   mem_write_data                       engine -> memory
//   mem_read_data                        memory -> engine (combinational)
// ---------------------------------------------------------------------------
interface mem_copy_engine_if #(
  parameter int DATA_W = 34,
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [LEN_W-1:0]  length;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] checksum;
  logic              mem_write_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output start, src_addr, dst_addr, length, mem_read_data,
    input  busy, done, err, checksum, mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    input  start, src_addr, dst_addr, length, mem_read_data,
    output busy, done, err, checksum, mem_write_enable, mem_address, mem_write_data
  );
endinterface

// File: rtl/mem_copy_engine.sv
// ---------------------------------------------------------------------------
// mem_copy_engine
// Copies a block of words inside a single-port 2**ADDR_W x DATA_W memory,
// one word per READ/WRITE cycle pair. The copy direction is chosen so that an
// overlapping source is never overwritten before it has been read.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  mem_copy_engine_if.slave (request handshake + memory bus)
// Build option:
//   MEM_COPY_CHECKSUM_EN  when defined, checksum accumulates every word read
//                         (mod 2**DATA_W); otherwise checksum is tied to 0.
// ---------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int DATA_W = 34,
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
) (
  input logic                clk,
  input logic                rst,
  mem_copy_engine_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              descending;
  logic [DATA_W-1:0] word_buf;
  logic              err_q;

  logic [ADDR_W-1:0] delta;
  logic              desc_req;
  logic              too_long;
  logic [ADDR_W-1:0] len_lo;

  // Pointer step wraps naturally mod 2**ADDR_W.
  function automatic logic [ADDR_W-1:0] step(input logic [ADDR_W-1:0] a,
                                             input logic down);
    return down ? (a - ADDR_ONE) : (a + ADDR_ONE);
  endfunction

  // Destination lies strictly inside the source window (going up) exactly
  // when 0 < (dst - src) mod DEPTH < length; only then must we copy from the
  // top end down.
  assign delta    = bus.dst_addr - bus.src_addr;
  assign desc_req = (delta != '0) && (LEN_W'(delta) < bus.length);
  assign too_long = bus.length > LEN_MAX;
  assign len_lo   = bus.length[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (too_long || (bus.length == '0)) state_next = DONE;
          else                                state_next = READ;
        end
      end
      READ:    state_next = WRITE;
      WRITE:   state_next = (remaining == LEN_ONE) ? DONE : READ;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_ptr    <= '0;
      dst_ptr    <= '0;
      remaining  <= '0;
      descending <= 1'b0;
      word_buf   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            err_q      <= too_long;
            remaining  <= bus.length;
            descending <= desc_req;
            // length = DEPTH truncates len_lo to 0, giving src-1: still the
            // correct last word mod DEPTH.
            if (desc_req) begin
              src_ptr <= bus.src_addr + len_lo - ADDR_ONE;
              dst_ptr <= bus.dst_addr + len_lo - ADDR_ONE;
            end else begin
              src_ptr <= bus.src_addr;
              dst_ptr <= bus.dst_addr;
            end
          end
        end
        READ: begin
          word_buf <= bus.mem_read_data;
        end
        WRITE: begin
          src_ptr   <= step(src_ptr, descending);
          dst_ptr   <= step(dst_ptr, descending);
          remaining <= remaining - LEN_ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      sum_q <= '0;
    end else if (state == READ) begin
      sum_q <= sum_q + bus.mem_read_data;
    end
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif

  // Memory bus and status are decoded straight from the state so that an
  // asynchronous reset drops the write strobe in the same instant.
  assign bus.busy             = (state == READ) || (state == WRITE);
  assign bus.done             = (state == DONE);
  assign bus.err              = err_q;
  assign bus.mem_write_enable = (state == WRITE);
  assign bus.mem_address      = (state == READ)  ? src_ptr :
                                (state == WRITE) ? dst_ptr : '0;
  assign bus.mem_write_data   = (state == WRITE) ? word_buf : '0;

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Initiator-side controller for the single-port 128 x 34-bit memory (write_enable / address / write_data, combinational read_data).
- Copies a block of words from a source address range to a destination range in that memory, one word at a time.
- Driven by a start/busy/done handshake from the top-level controller.
- Overlap-safe: chooses ascending or descending copy order so the source is never overwritten before it is read.

Parameters:
- DATA_W, 34, memory word width.
- ADDR_W, 7, memory address width; depth = 2**ADDR_W = 128.
- LEN_W, 8, width of the length field; must hold 0..2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- src_addr  input  ADDR_W  first source word.
- dst_addr  input  ADDR_W  first destination word.
- length  input  LEN_W  number of words, 0..128.
- busy  output  1  high while a copy is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid with done; 1 = request rejected.
- checksum  output  DATA_W  sum of copied words (see Optional Feature).
- mem_write_enable  output  1  to memory write_enable.
- mem_address  output  ADDR_W  to memory address.
- mem_write_data  output  DATA_W  to memory write_data.
- mem_read_data  input  DATA_W  from memory read_data; combinational in mem_address.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, err=0, checksum=0, mem_write_enable=0, mem_address=0, mem_write_data=0; internal counters and buffer cleared. Reset mid-copy aborts immediately with no further writes and no done pulse.
- States: IDLE, READ, WRITE, DONE.
- IDLE, on start=1 at a rising edge:
  - latch src_addr, dst_addr, length;
  - length>128: go to DONE with err=1, no memory writes;
  - length=0: go to DONE with err=0;
  - otherwise go to READ, busy=1.
- Start while not in IDLE is ignored.
- Direction: d = (dst_addr - src_addr) mod 128.
  - 0 < d < length: descending; first pair is (src+length-1, dst+length-1), both decrement.
  - otherwise: ascending; both increment.
- All address arithmetic wraps mod 128 (e.g. 127+1=0, 0-1=127).
- READ (1 cycle): mem_address=current source, mem_write_enable=0; capture mem_read_data into the word buffer at the clock edge.
- WRITE (1 cycle): mem_address=current destination, mem_write_data=buffer, mem_write_enable=1.
  - Then advance both pointers and decrement the remaining count.
  - Remaining=0 → DONE, else → READ.
- DONE (1 cycle): done=1, busy=0, mem_write_enable=0; then IDLE. err holds its value through DONE and clears on the next accepted start.
- Latency: a start accepted at edge t0 gives busy high for 2N cycles and done high in cycle 2N+1. Throughput is 2 cycles per word; exactly N writes occur.
- d=0 (src=dst): still performs N read/write pairs; memory contents unchanged.
- mem_write_enable is never high outside WRITE.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- Defined:
  - checksum is cleared when a start is accepted;
  - each word captured in READ is added to it, mod 2**DATA_W;
  - checksum is valid when done is high and holds until the next accepted start.
- Not defined: checksum is constant 0 and no adder is synthesized.

Test Plan:
- Ascending copy: mem[10..13]=0x1,0x2,0x3,0x3FFFFFFFF; src=10, dst=40, len=4 → mem[40..43] equal the source, done in cycle 9, exactly 4 write cycles, err=0; with the macro defined, checksum = 0x000000005 (wrap mod 2**34).
- Overlapping copy: mem[20..24]=A..E; src=20, dst=22, len=5 → descending order, mem[22..26]=A..E, mem[20..21] unchanged.
- Wrap-around: src=126, dst=5, len=4 → mem[5..8] = old mem[126], mem[127], mem[0], mem[1].
- Length boundaries:
  - len=0 → done in cycle 1, err=0, no writes;
  - len=129 → done in cycle 1, err=1, no writes;
  - len=128 with src=0, dst=0 → 256 busy cycles, memory unchanged.
- Reset mid-operation: assert rst=0 during the 3rd WRITE of a len=8 copy → mem_write_enable drops immediately, busy=0, no done pulse; a later start completes normally.
- Start while busy: pulse start with new arguments mid-copy → ignored; the original copy finishes with a single done pulse.
